fft_stream_ctrl: RTL
====================

# fft_stream_ctrl

Streaming front/back end for the `fft` core, parametrised in sample width and transform size (N = 2**N_2).
- Input side: accepts real samples over a valid/ready handshake and drives the core's `load`/`start` protocol.
- Output side: captures the core's non-stallable `done` output burst into an N-deep frame buffer, then replays it downstream over valid/ready with a frame-end marker.
- Sits between the sample source and the result consumer, and turns the FFT into a back-pressurable stream stage.

## Interface
Parameters:
- `width`, 16, sample/component width in bits; complex words are 2*`width` wide as {re, im}.
- `N_2`, 5, log2 of transform size; N = 2**`N_2`.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  input sample valid.
- `in_ready`  out  1  controller accepts a sample.
- `in_data`  in  `width`  signed real sample.
- `out_valid`  out  1  output bin valid.
- `out_ready`  in  1  downstream accepts a bin.
- `out_data`  out  2*`width`  {re, im} FFT bin, natural order.
- `out_last`  out  1  high with bin N-1.
- `fft_load`  out  1  to core `load`; one sample is written per high cycle.
- `fft_start`  out  1  to core `start`; one-cycle pulse.
- `fft_rd`  out  `width`  to core `rd`.
- `fft_wd`  in  2*`width`  from core `wd`.
- `fft_done`  in  1  from core `done`.

## Operation
- FSM states: LOAD, START, WAIT, CAPTURE, DRAIN.
- LOAD:
  - `in_ready`=1.
  - `fft_load`=`in_valid`; `fft_rd`=`in_data`.
  - Accepted samples increment `in_cnt` (`N_2`+1 bits).
  - After the N-th accepted sample, go to START; `in_cnt` clears.
- START: `fft_start`=1 for exactly one cycle, then WAIT.
- WAIT:
  - Samples `fft_done`. The first cycle it is high, `fft_wd` is bin 0: write it to buffer[0] and go to CAPTURE with `cap_cnt`=1.
  - `fft_done` is ignored in every state other than WAIT and CAPTURE.
- CAPTURE:
  - Writes `fft_wd` to buffer[`cap_cnt`] every cycle, unconditionally. The core cannot stall.
  - After buffer[N-1] is written, go to DRAIN.
- DRAIN:
  - `out_valid`=1; `out_data`=buffer[`rd_idx`] via combinational read; `out_last`=(`rd_idx`==N-1).
  - `rd_idx` advances on `out_valid`&`out_ready`.
  - The handshake on the last bin returns the FSM to LOAD with `rd_idx`=0.
- Outputs are never modified by the controller; no scaling, no rounding.
- Reset values: state LOAD, all counters 0, `in_ready`=1 in the first cycle after reset, `out_valid`=0, `out_last`=0, `fft_load`=0 (when `in_valid`=0), `fft_start`=0, `fft_rd`=`in_data`.
- Reset mid-frame:
  - Drops the partial frame and any undrained buffer contents.
  - The core shares `reset`, so both restart together.
- Wrap: `rd_idx` and `cap_cnt` are `N_2`+1 bits and compared against N; they never wrap silently.

## Timing
- `fft_start` rises the cycle after the N-th input handshake.
- Core latency is data-dependent to the controller; WAIT has no timeout.
- `out_valid` rises the cycle after the capture of bin N-1.
- Throughput is bounded by `out_ready`: N cycles per frame minimum in DRAIN.
- No overlap: `in_ready`=0 from START until the last output handshake.
- `out_valid` and `out_data` hold stable while `out_ready`=0.

## Configuration
- `FFT_IN_LAST_EN` defined: adds port `in_last` (in, 1).
  - `in_last` on an accepted sample k<N-1 triggers zero padding: `in_ready`=0, `fft_load`=1 and `fft_rd`=0 for N-1-k further cycles, then START.
  - `in_last` on sample N-1 behaves as normal.
  - `in_last` absent at sample N-1: the frame still ends at N samples, and the next sample starts a new frame.
- `FFT_IN_LAST_EN` undefined: no `in_last` port, and frames are exactly N accepted samples.

## Structure
- Package `fft_pkg`:
  - `fft_state_t` enum (LOAD, START, WAIT, CAPTURE, DRAIN).
  - Parametrised complex split helpers: re = [2w-1:w], im = [w-1:0].
- Sub-module `fft_frame_buffer` #(`width`, `N_2`):
  - N x 2*`width` storage.
  - Synchronous write port (we, wadr, wd).
  - Combinational read port (radr, rd).

## Test plan
The bench uses a behavioural core model: `done` goes high 10 cycles after `start` and streams bin k = {k, ~k} for k = 0..N-1.
- Default N=32, `in_valid` held high, `out_ready` high:
  - `fft_load` is high for exactly 32 cycles; `fft_start` pulses once the next cycle.
  - Bins appear in order; `out_last` is high only on bin 31 = {16'h001F, 16'hFFE0}.
- `in_valid` toggling 1010…: `fft_load` mirrors the accepted cycles only; `fft_start` pulses after the 32nd acceptance, at cycle 63 after reset release.
- `out_ready` low for 20 cycles at bin 5:
  - `out_data` holds at {16'h0005, 16'hFFFA} throughout.
  - `in_ready` stays 0; no bin is lost or duplicated.
- `reset` asserted during CAPTURE at bin 12:
  - Next cycle: `out_valid`=0, `in_ready`=1, state LOAD.
  - A fresh frame then completes normally.
- `N_2`=3, `width`=12: an 8-sample frame yields 8 bins with `out_last` on bin 7; a back-to-back second frame has `fft_start` count = 2.
- `FFT_IN_LAST_EN`, `in_last` on sample 19 of 32: 12 zero-pad cycles with `fft_rd`=0 and `in_ready`=0, then `fft_start`.

Source files
------------

// File: rtl/fft_stream_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | fft_pkg : shared types and complex-word helpers for fft_stream_ctrl
// | Revision: 1.0
// +----------------------------------------------------------------------------
package fft_pkg;

  typedef enum logic [2:0] {
    LOAD    = 3'd0,
    START   = 3'd1,
    WAIT    = 3'd2,
    CAPTURE = 3'd3,
    DRAIN   = 3'd4
  } fft_state_t;

  localparam int c_cplx_max_w = 32;

  // Complex words are {re, im}, each w bits; results are zero-extended.
  function automatic logic [c_cplx_max_w-1:0] cplx_re(
    input logic [2*c_cplx_max_w-1:0] c,
    input int                        w
  );
    logic [2*c_cplx_max_w-1:0] m;
    logic [2*c_cplx_max_w-1:0] t;
    m = (64'(1) << w) - 64'(1);
    t = (c >> w) & m;
    return t[c_cplx_max_w-1:0];
  endfunction

  function automatic logic [c_cplx_max_w-1:0] cplx_im(
    input logic [2*c_cplx_max_w-1:0] c,
    input int                        w
  );
    logic [2*c_cplx_max_w-1:0] m;
    logic [2*c_cplx_max_w-1:0] t;
    m = (64'(1) << w) - 64'(1);
    t = c & m;
    return t[c_cplx_max_w-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/fft_stream_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | fft_stream_ctrl_if : sample/bin streams plus fft core handshake
// | Optional in_last under FFT_IN_LAST_EN.  Revision: 1.0
// +----------------------------------------------------------------------------
interface fft_stream_ctrl_if #(
  parameter int width = 16
) ();
  logic               in_valid;
  logic               in_ready;
  logic [width-1:0]   in_data;
`ifdef FFT_IN_LAST_EN
  logic               in_last;
`endif
  logic               out_valid;
  logic               out_ready;
  logic [2*width-1:0] out_data;
  logic               out_last;
  logic               fft_load;
  logic               fft_start;
  logic [width-1:0]   fft_rd;
  logic [2*width-1:0] fft_wd;
  logic               fft_done;

  // slave: the controller; master: sample source, consumer and core
  modport slave (
`ifdef FFT_IN_LAST_EN
    input  in_last,
`endif
    input  in_valid, in_data, out_ready, fft_wd, fft_done,
    output in_ready, out_valid, out_data, out_last, fft_load, fft_start, fft_rd
  );

  modport master (
`ifdef FFT_IN_LAST_EN
    output in_last,
`endif
    output in_valid, in_data, out_ready, fft_wd, fft_done,
    input  in_ready, out_valid, out_data, out_last, fft_load, fft_start, fft_rd
  );
endinterface
`default_nettype wire

// File: rtl/fft_stream_ctrl_frame_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | fft_frame_buffer : N x 2*width store, sync write, combinational read
// | Revision: 1.0
// +----------------------------------------------------------------------------
module fft_frame_buffer #(
  parameter int width = 16,
  parameter int N_2   = 5
) (
  input  logic               clk,
  input  logic               we,
  input  logic [N_2-1:0]     wadr,
  input  logic [2*width-1:0] wd,
  input  logic [N_2-1:0]     radr,
  output logic [2*width-1:0] rd
);
  logic [2*width-1:0] r_mem [2**N_2];

  always_ff @(posedge clk) begin
    if (we) r_mem[wadr] <= wd;
  end

  assign rd = r_mem[radr];
endmodule
`default_nettype wire

// File: rtl/fft_stream_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | fft_stream_ctrl : stream front/back end for the fft core (load/start/done)
// | FFT_IN_LAST_EN adds in_last with zero padding.  Revision: 1.0
// +----------------------------------------------------------------------------
module fft_stream_ctrl
  import fft_pkg::*;
#(
  parameter int width = 16,
  parameter int N_2   = 5
) (
  input  logic             clk,
  input  logic             reset,
  fft_stream_ctrl_if.slave bus
);
  localparam int           c_n    = 1 << N_2;
  localparam logic [N_2:0] c_last = (N_2+1)'(c_n - 1);

  fft_state_t         r_state;
  logic [N_2:0]       r_in_cnt;
  logic [N_2:0]       r_cap_cnt;
  logic [N_2:0]       r_rd_idx;
  logic               r_in_ready;
  logic               r_out_valid;
  logic               r_fft_start;
  logic               w_pad;
  logic               w_in_hs;
  logic               w_we;
  logic [N_2-1:0]     w_wadr;
  logic [2*width-1:0] w_rd_data;

`ifdef FFT_IN_LAST_EN
  logic r_pad;
  assign w_pad = r_pad;
`else
  assign w_pad = 1'b0;
`endif

  // r_in_ready is only ever high in LOAD outside zero padding
  assign w_in_hs = bus.in_valid & r_in_ready;
  assign w_we    = ((r_state == WAIT) & bus.fft_done) | (r_state == CAPTURE);
  assign w_wadr  = (r_state == CAPTURE) ? r_cap_cnt[N_2-1:0] : '0;

  assign bus.in_ready  = r_in_ready;
  assign bus.fft_load  = (r_state == LOAD) & (w_pad | w_in_hs);
  assign bus.fft_rd    = w_pad ? '0 : bus.in_data;
  assign bus.fft_start = r_fft_start;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = w_rd_data;
  assign bus.out_last  = r_out_valid & (r_rd_idx == c_last);

  fft_frame_buffer #(.width(width), .N_2(N_2)) u_buf (
    .clk  (clk),
    .we   (w_we),
    .wadr (w_wadr),
    .wd   (bus.fft_wd),
    .radr (r_rd_idx[N_2-1:0]),
    .rd   (w_rd_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= LOAD;
      r_in_cnt    <= '0;
      r_cap_cnt   <= '0;
      r_rd_idx    <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_fft_start <= 1'b0;
`ifdef FFT_IN_LAST_EN
      r_pad       <= 1'b0;
`endif
    end else begin
      r_fft_start <= 1'b0;
      case (r_state)
        LOAD: begin
`ifdef FFT_IN_LAST_EN
          if (r_pad) begin
            if (r_in_cnt == c_last) begin
              r_in_cnt    <= '0;
              r_pad       <= 1'b0;
              r_fft_start <= 1'b1;
              r_state     <= START;
            end else begin
              r_in_cnt <= r_in_cnt + 1'b1;
            end
          end else
`endif
          if (w_in_hs) begin
            if (r_in_cnt == c_last) begin
              r_in_cnt    <= '0;
              r_in_ready  <= 1'b0;
              r_fft_start <= 1'b1;
              r_state     <= START;
            end
`ifdef FFT_IN_LAST_EN
            else if (bus.in_last) begin
              r_pad      <= 1'b1;
              r_in_ready <= 1'b0;
              r_in_cnt   <= r_in_cnt + 1'b1;
            end
`endif
            else begin
              r_in_cnt <= r_in_cnt + 1'b1;
            end
          end
        end
        START: r_state <= WAIT;
        WAIT: begin
          if (bus.fft_done) begin
            r_cap_cnt <= (N_2+1)'(1);
            r_state   <= CAPTURE;
          end
        end
        CAPTURE: begin
          // The core streams without pause, so every cycle here is a write
          if (r_cap_cnt == c_last) begin
            r_cap_cnt   <= '0;
            r_out_valid <= 1'b1;
            r_state     <= DRAIN;
          end else begin
            r_cap_cnt <= r_cap_cnt + 1'b1;
          end
        end
        DRAIN: begin
          if (bus.out_ready) begin
            if (r_rd_idx == c_last) begin
              r_rd_idx    <= '0;
              r_out_valid <= 1'b0;
              r_in_ready  <= 1'b1;
              r_state     <= LOAD;
            end else begin
              r_rd_idx <= r_rd_idx + 1'b1;
            end
          end
        end
        default: r_state <= LOAD;
      endcase
    end
  end
endmodule
`default_nettype wire
